port_out_uart_tx: RTL and testbench

PORT_OUT_UART_TX -- requirements
Module: port_out_uart_tx

---
 rtl/port_out_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_port_out_uart_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/port_out_uart_tx.sv
// Buffers 32-bit PortOut words in a small FIFO and serialises each one as four
// 8N1 UART frames, low byte first, on a registered tx line.
module port_out_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        word_valid,
    input  logic [31:0] word_in,
    output logic        word_ready,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CntW-1:0]   FullCount = CntW'(FIFO_DEPTH);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // FIFO storage and bookkeeping
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q;
    logic            full, empty, push, pop;

    // Transmitter state
    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              timer_last;

    assign full       = (count_q == FullCount);
    assign empty      = (count_q == '0);
    assign word_ready = ~full;
    // full comes from the registered count, so a word offered while full is
    // dropped even if the transmitter pops in the same cycle.
    assign push       = word_valid & ~full;
    assign timer_last = (timer_q == TimerLast);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
            if (word_valid && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= word_in;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d    = StStart;
                    shift_d    = mem_q[rd_ptr_q];
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    timer_d    = '0;
                end
            end
            StStart: begin
                if (timer_last) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StData: begin
                if (timer_last) begin
                    timer_d = '0;
                    // After eight shifts the next byte sits in the low bits.
                    shift_d = {1'b0, shift_q[31:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StStop: begin
                if (timer_last) begin
                    timer_d = '0;
                    if (byte_idx_q == 2'd3) begin
                        state_d = StIdle;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = StStart;
                    end
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic; tx is registered so the line lags the state by one cycle.
    always_comb begin
        tx_d = 1'b1;
        pop  = 1'b0;
        unique case (state_q)
            StIdle:  pop  = ~empty;
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_q[0];
            StStop:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign busy     = (state_q != StIdle) | ~empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_port_out_uart_tx.sv
// Bench for port_out_uart_tx: a queue-and-timeline model of the FIFO and UART
// framing is compared against the DUT every cycle, plus literal spot checks.
module tb_port_out_uart_tx;

    localparam int CPB    = 4;
    localparam int DEPTH  = 4;
    localparam int BYTE_T = 10 * CPB;
    localparam int FRAME  = 40 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        word_valid = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_ready, tx, busy, overflow;

    port_out_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .word_valid(word_valid),
        .word_in   (word_in),
        .word_ready(word_ready),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: queued words, the cycle the transmitter is next idle, and the
    // timeline of the frame currently on the line.
    logic [31:0] mq[$];
    int          idle_at     = 0;
    int          frame_first = -100000;
    logic [31:0] frame_word  = '0;
    bit          m_ovf       = 1'b0;
    bit          model_ok    = 1'b0;
    bit          do_pop, was_full;

    bit          a5_bits   [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    logic [7:0]  exp_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    endtask

    function automatic logic exp_tx(input int m);
        int k, b, slot;
        if (m < frame_first || m >= frame_first + FRAME) return 1'b1;
        k    = m - frame_first;
        b    = k / BYTE_T;
        slot = (k % BYTE_T) / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return frame_word[b*8 + slot - 1];
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mq.delete();
            idle_at     = cyc;
            frame_first = -100000;
            m_ovf       = 1'b0;
            model_ok    = 1'b1;
        end else if (model_ok) begin
            do_pop   = (cyc - 1 >= idle_at) && (mq.size() > 0);
            was_full = (mq.size() == DEPTH);
            if (do_pop) begin
                frame_word  = mq.pop_front();
                frame_first = cyc + 1;
                idle_at     = cyc + FRAME;
            end
            if (word_valid) begin
                if (was_full) m_ovf = 1'b1;
                else mq.push_back(word_in);
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("tx", tx, exp_tx(cyc));
            check("busy", busy, (cyc < idle_at) || (mq.size() != 0));
            check("word_ready", word_ready, mq.size() < DEPTH);
            check("overflow", overflow, m_ovf);
        end
    end

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && busy === 1'b1; i++) @(negedge clk);
        check("drain busy", busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int         e, s, dens;
        logic [7:0] got;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset tx", tx, 1'b1);
        check("reset word_ready", word_ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset overflow", overflow, 1'b0);

        // Single 0xA5 word: two-cycle latency, LSB-first bits, 160-cycle frame.
        word_valid = 1'b1; word_in = 32'h0000_00A5;
        @(negedge clk);
        word_valid = 1'b0;
        e = cyc; s = e + 2;
        wait_to(s - 1); check("a5 pre-start", tx, 1'b1);
        wait_to(s);     check("a5 start", tx, 1'b0);
        check("a5 busy", busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            wait_to(s + CPB * (i + 1) + 1);
            check("a5 bit", tx, a5_bits[i]);
        end
        wait_to(s + 9 * CPB + 1);     check("a5 stop", tx, 1'b1);
        wait_to(s + BYTE_T);          check("a5 byte1 start", tx, 1'b0);
        wait_to(s + BYTE_T + CPB + 1); check("a5 byte1 bit0", tx, 1'b0);
        wait_to(s + FRAME - 2);       check("a5 busy late", busy, 1'b1);
        wait_to(s + FRAME - 1);       check("a5 last stop", tx, 1'b1);
        wait_to(s + FRAME);           check("a5 after tx", tx, 1'b1);
        check("a5 after busy", busy, 1'b0);
        drain(FRAME);

        // Decode 0x44332211 at mid-bit; start bits directly follow stop bits.
        word_valid = 1'b1; word_in = 32'h4433_2211;
        @(negedge clk);
        word_valid = 1'b0;
        s = cyc + 2;
        for (int b = 0; b < 4; b++) begin
            wait_to(s + BYTE_T * b);
            check("byte start", tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
                wait_to(s + BYTE_T * b + CPB * (i + 1) + CPB / 2);
                got[i] = tx;
            end
            check("decoded byte", got, exp_bytes[b]);
            wait_to(s + BYTE_T * b + 9 * CPB + CPB / 2);
            check("byte stop", tx, 1'b1);
        end
        drain(FRAME + 20);

        // Five back-to-back pushes fill the FIFO; the sixth is dropped.
        for (int i = 0; i < 5; i++) begin
            word_valid = 1'b1; word_in = $urandom;
            @(negedge clk);
        end
        check("five pushes ready", word_ready, 1'b0);
        check("five pushes overflow", overflow, 1'b0);
        word_in = $urandom;
        @(negedge clk);
        word_valid = 1'b0;
        check("sixth dropped overflow", overflow, 1'b1);
        check("sixth dropped ready", word_ready, 1'b0);
        repeat (50) @(negedge clk);
        check("overflow held", overflow, 1'b1);
        drain(6 * FRAME);

        // Reset in the data bits of byte 2 with words still buffered.
        word_valid = 1'b1; word_in = $urandom;
        @(negedge clk);
        e = cyc;
        word_in = $urandom;
        @(negedge clk);
        word_in = $urandom;
        @(negedge clk);
        word_valid = 1'b0;
        s = e + 2;
        wait_to(s + 2 * BYTE_T + 3 * CPB + 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort tx", tx, 1'b1);
        check("abort ready", word_ready, 1'b1);
        check("abort overflow", overflow, 1'b0);
        check("abort busy", busy, 1'b0);
        repeat (FRAME) @(negedge clk);
        check("post-abort busy", busy, 1'b0);
        check("post-abort tx", tx, 1'b1);

        // Hold valid while full through the pop edge: drop leaves DEPTH-1 words.
        for (int i = 0; i < 5; i++) begin
            word_valid = 1'b1; word_in = $urandom;
            @(negedge clk);
            if (i == 0) e = cyc;
        end
        word_in = $urandom;
        wait_to(e + FRAME + 1); check("full before pop", word_ready, 1'b0);
        wait_to(e + FRAME + 2);
        word_valid = 1'b0;
        check("drop on pop ready", word_ready, 1'b1);
        check("drop on pop overflow", overflow, 1'b1);
        @(negedge clk);
        check("depth-1 stays", word_ready, 1'b1);
        drain(5 * FRAME);

        // Two consecutive pushes: exactly one idle-high cycle between words.
        word_valid = 1'b1; word_in = $urandom;
        @(negedge clk);
        e = cyc;
        word_in = $urandom;
        @(negedge clk);
        word_valid = 1'b0;
        s = e + 2;
        wait_to(s + FRAME - 1); check("w1 last stop", tx, 1'b1);
        wait_to(s + FRAME);     check("inter-word idle", tx, 1'b1);
        wait_to(s + FRAME + 1); check("w2 start", tx, 1'b0);
        drain(2 * FRAME);

        // Randomised traffic with varying density and rare resets.
        dens = 20;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dens = $urandom_range(2, 70);
            reset      = ($urandom_range(0, 599) == 0);
            word_valid = ($urandom_range(0, 99) < dens);
            word_in    = $urandom;
            @(negedge clk);
        end
        reset = 1'b0;
        word_valid = 1'b0;
        drain(6 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
